// File: rtl/tick_divider_bank.sv
// Bank of N_CH independent runtime-programmable clock-enable generators.
// Each channel emits a registered 1-cycle tick and a 50%-duty square output.

module tick_divider_ch #(
    parameter int               DIV_W   = 32,
    parameter logic [DIV_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             sq_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [DIV_W-1:0] div_eff;
    logic             terminal;

    // A programmed divisor of 0 is treated as 1 so the counter can never run away.
    assign div_eff  = (div_q == '0) ? DIV_W'(1) : div_q;
    assign terminal = (cnt_q == div_eff - DIV_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (wr_i) begin
                div_d = wr_div_i;
            end
        end else if (wr_i) begin
            // Restart the period on the new divisor; the square level is kept.
            div_d = wr_div_i;
            cnt_d = '0;
        end else if (en_i) begin
            if (terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d  = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

module tick_divider_bank #(
    parameter int                     N_CH        = 3,
    parameter int                     DIV_W       = 32,
    parameter logic [N_CH*DIV_W-1:0]  DEFAULT_DIV = {32'd4, 32'd50_000, 32'd50_000_000}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [2:0]       wr_ch_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  sq_o
);

    typedef struct packed {
        logic             en;
        logic [2:0]       ch;
        logic [DIV_W-1:0] div;
    } wr_req_t;

    wr_req_t         wr_req;
    logic [N_CH-1:0] wr_hit;

    assign wr_req = '{en: wr_en_i, ch: wr_ch_i, div: wr_div_i};

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            // Index match alone rejects out-of-range channels: no channel carries those indices.
            assign wr_hit[i] = wr_req.en && (wr_req.ch == 3'(i));

            tick_divider_ch #(
                .DIV_W   (DIV_W),
                .RST_DIV (DEFAULT_DIV[i*DIV_W +: DIV_W])
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .en_i     (en_i),
                .clr_i    (clr_i),
                .wr_i     (wr_hit[i]),
                .wr_div_i (wr_req.div),
                .tick_o   (tick_o[i]),
                .sq_o     (sq_o[i])
            );
        end
    endgenerate

endmodule
